perf_counter_ctrl: RTL and testbench

//  Bank of NUM_EVENTS event counters plus a control register, exposed as a word-aligned

---
 rtl/perf_pkg.sv | 17 +
 rtl/perf_event_counter.sv | 45 ++++
 rtl/perf_counter_ctrl.sv | 136 +++++++++++++
 tb/tb_perf_counter_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-counter slave.
// The FSM state, CTRL bit positions and the width of a word index live here.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } perf_state_t;

  localparam int EN_BIT  = 0;
  localparam int CLR_BIT = 1;

  // Enough bits to address up to 15 counters plus the CTRL word.
  localparam int IDX_W = 4;

endpackage

// File: rtl/perf_event_counter.sv
// One event-counter slice: rising-edge detection on a level strobe, with load and clear.
// Clear beats load, and load beats increment; the armed flag always follows the strobe.
module perf_event_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             strobe,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             armed_reg;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = load_value;
    end else if (enable && strobe && !armed_reg) begin
      count_next = count_reg + WIDTH'(1);
    end
  end

  // Arming is tracked even while disabled or loading, so a strobe that is
  // already high when counting resumes (or when software writes) never counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      armed_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      armed_reg <= strobe;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/perf_counter_ctrl.sv
// Memory-mapped bank of event counters plus a CTRL word (EN, self-clearing CLR_ALL).
// A three-state sequencer gives every hit a fixed two-cycle response latency.
module perf_counter_ctrl
  import perf_pkg::*;
#(
  parameter int          NUM_EVENTS = 8,
  parameter int          WIDTH      = 16,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [31:0]           mem_address,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_hit,
  output logic                  mem_resp,
  output logic [31:0]           mem_rdata
);

  perf_state_t state_reg;
  perf_state_t state_next;

  logic [29:0]      word_idx;
  logic             accept;
  logic [IDX_W-1:0] idx_reg;
  logic             write_reg;
  logic [31:0]      wdata_reg;
  logic             en_reg;
  logic [31:0]      rdata_reg;
  logic [31:0]      read_value;

  logic             do_read;
  logic             do_write;
  logic             ctrl_sel;
  logic             clear_all;

  logic [NUM_EVENTS-1:0] load_sel;
  logic [WIDTH-1:0]      count [NUM_EVENTS];

  // The base is 64-byte aligned, so the word offset can be formed from bits [31:2]
  // alone; addresses below the base wrap to a huge index and miss.
  assign word_idx = mem_address[31:2] - BASE_ADDR[31:2];
  assign mem_hit  = (word_idx <= 30'(NUM_EVENTS));
  assign accept   = (state_reg == IDLE) && (mem_read || mem_write) && mem_hit;

  always_comb begin
    state_next = state_reg;
    mem_resp   = 1'b0;
    do_read    = 1'b0;
    do_write   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = ACCESS;
      end
      ACCESS: begin
        do_read    = !write_reg;
        do_write   = write_reg;
        state_next = RESP;
      end
      RESP: begin
        mem_resp   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ctrl_sel  = (idx_reg == IDX_W'(NUM_EVENTS));
  assign clear_all = do_write && ctrl_sel && wdata_reg[CLR_BIT];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
      en_reg    <= 1'b1;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      // A simultaneous read and write is treated as a write.
      if (accept) begin
        idx_reg   <= word_idx[IDX_W-1:0];
        write_reg <= mem_write;
        wdata_reg <= mem_wdata;
      end
      if (do_write && ctrl_sel) begin
        en_reg <= wdata_reg[EN_BIT];
      end
      if (do_read) begin
        rdata_reg <= read_value;
      end
    end
  end

  // CLR_ALL is never stored, so it always reads back as zero.
  always_comb begin
    read_value = '0;
    if (ctrl_sel) begin
      read_value[EN_BIT] = en_reg;
    end
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        read_value[WIDTH-1:0] = count[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_counter
      assign load_sel[gi] = do_write && (idx_reg == IDX_W'(gi));

      perf_event_counter #(
        .WIDTH(WIDTH)
      ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .enable    (en_reg),
        .strobe    (event_i[gi]),
        .load      (load_sel[gi]),
        .load_value(wdata_reg[WIDTH-1:0]),
        .clear     (clear_all),
        .count     (count[gi])
      );
    end
  endgenerate

  assign mem_rdata = rdata_reg;

  // Byte-lane bits and unused write-data bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{mem_address[1:0], wdata_reg};

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Directed bench for perf_counter_ctrl: counting, wrap, enable, write/event collision,
// clear-all, decode boundaries and reset during an access.
module tb_perf_counter_ctrl;

  localparam int          NE   = 8;
  localparam int          W    = 16;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic          clk = 1'b0;
  logic          reset;
  logic [NE-1:0] event_i;
  logic [31:0]   mem_address;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_wdata;
  logic          mem_hit;
  logic          mem_resp;
  logic [31:0]   mem_rdata;

  int nvec  = 0;
  int nfail = 0;

  perf_counter_ctrl #(
    .NUM_EVENTS(NE),
    .WIDTH     (W),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .event_i    (event_i),
    .mem_address(mem_address),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_hit    (mem_hit),
    .mem_resp   (mem_resp),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus transaction; ev_mask strobes are raised during the ACCESS cycle.
  task automatic bus_op(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [31:0] wdata, input logic [NE-1:0] ev_mask,
                        output logic [31:0] rdata);
    int lat;
    lat         = -1;
    rdata       = '0;
    mem_address = addr;
    mem_read    = rd;
    mem_write   = wr;
    mem_wdata   = wdata;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) event_i = event_i | ev_mask;
      if (mem_resp) begin
        lat   = c;
        rdata = mem_rdata;
        break;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    $display("txn addr=0x%08h rd=%0b wr=%0b wdata=0x%0h rdata=0x%0h latency=%0d",
             addr, rd, wr, wdata, rdata, lat);
    chk("latency", 32'(lat), 32'd2);
    tick();
  endtask

  task automatic rd_idx(input int idx, output logic [31:0] data);
    bus_op(BASE + 32'(idx * 4), 1'b1, 1'b0, 32'h0, '0, data);
  endtask

  task automatic wr_idx(input int idx, input logic [31:0] data, input logic [NE-1:0] ev_mask);
    logic [31:0] dummy;
    bus_op(BASE + 32'(idx * 4), 1'b0, 1'b1, data, ev_mask, dummy);
  endtask

  task automatic pulse(input int bitn);
    event_i[bitn] = 1'b1;
    tick();
    event_i[bitn] = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] d;
    int resp_seen;

    reset       = 1'b1;
    event_i     = '0;
    mem_address = BASE;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = '0;
    repeat (3) tick();
    chk("reset_resp", 32'(mem_resp), 32'd0);
    chk("reset_rdata", mem_rdata, 32'h0);
    reset = 1'b0;
    tick();
    rd_idx(NE, d);
    chk("reset_ctrl", d, 32'h1);
    rd_idx(7, d);
    chk("reset_cnt7", d, 32'h0);

    // 1: long assertion counts once, short one counts once more
    event_i[0] = 1'b1;
    repeat (5) tick();
    event_i[0] = 1'b0;
    tick();
    pulse(0);
    rd_idx(0, d);
    chk("cnt0_two_edges", d, 32'h2);

    // 2: wrap
    wr_idx(3, 32'h0000_FFFF, '0);
    rd_idx(3, d);
    chk("cnt3_loaded", d, 32'hFFFF);
    pulse(3);
    rd_idx(3, d);
    chk("cnt3_wrap", d, 32'h0);

    // 3: disable, events ignored, re-enable
    wr_idx(NE, 32'h0, '0);
    rd_idx(NE, d);
    chk("ctrl_en0", d, 32'h0);
    repeat (3) pulse(1);
    wr_idx(NE, 32'h1, '0);
    pulse(1);
    rd_idx(1, d);
    chk("cnt1_en", d, 32'h1);

    // 4: event edge in the ACCESS cycle of a write to the same counter
    wr_idx(2, 32'h10, NE'(8'h14));
    repeat (2) tick();
    event_i[2] = 1'b0;
    event_i[4] = 1'b0;
    tick();
    rd_idx(2, d);
    chk("cnt2_write_wins", d, 32'h10);
    rd_idx(4, d);
    chk("cnt4_counts", d, 32'h1);

    // 5: one edge on every counter, then clear-all
    event_i = '1;
    tick();
    event_i = '0;
    tick();
    rd_idx(0, d);
    chk("cnt0_before_clr", d, 32'h3);
    rd_idx(2, d);
    chk("cnt2_before_clr", d, 32'h11);
    wr_idx(NE, 32'h3, '0);
    for (int i = 0; i < NE; i++) begin
      rd_idx(i, d);
      chk($sformatf("cnt%0d_cleared", i), d, 32'h0);
    end
    rd_idx(NE, d);
    chk("ctrl_after_clr", d, 32'h1);

    // read and write together behave as a write
    bus_op(BASE + 32'd24, 1'b1, 1'b1, 32'h55, '0, d);
    rd_idx(6, d);
    chk("cnt6_rw_as_write", d, 32'h55);

    // 6: decode boundaries and a miss
    mem_address = BASE + 32'h20;
    #1;
    chk("hit_ctrl", 32'(mem_hit), 32'd1);
    mem_address = BASE + 32'h24;
    #1;
    chk("hit_past_ctrl", 32'(mem_hit), 32'd0);
    mem_address = BASE - 32'd4;
    #1;
    chk("hit_below_base", 32'(mem_hit), 32'd0);
    mem_address = BASE + 32'h40;
    #1;
    chk("hit_0x40", 32'(mem_hit), 32'd0);
    mem_read  = 1'b1;
    resp_seen = 0;
    repeat (5) begin
      tick();
      if (mem_resp) resp_seen++;
    end
    mem_read = 1'b0;
    tick();
    chk("miss_no_resp", 32'(resp_seen), 32'd0);

    // reset during ACCESS: no response, all state back to reset values
    pulse(5);
    wr_idx(NE, 32'h0, '0);
    mem_address = BASE + 32'd20;
    mem_read    = 1'b1;
    tick();
    reset     = 1'b1;
    resp_seen = 0;
    tick();
    if (mem_resp) resp_seen++;
    reset    = 1'b0;
    mem_read = 1'b0;
    repeat (4) begin
      tick();
      if (mem_resp) resp_seen++;
    end
    chk("reset_in_access_resp", 32'(resp_seen), 32'd0);
    chk("reset_in_access_rdata", mem_rdata, 32'h0);
    rd_idx(NE, d);
    chk("ctrl_after_reset", d, 32'h1);
    rd_idx(5, d);
    chk("cnt5_after_reset", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
